// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings and the parity mode
// constants, also used by the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_ODD  = 2'd1;
  localparam logic [1:0] PARITY_EVEN = 2'd2;

  // The unused encoding 3 behaves exactly like "no parity".
  function automatic logic [1:0] normalize_parity(input logic [1:0] mode);
    return (mode == 2'd3) ? PARITY_NONE : mode;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous line that idles high.
// Both flops reset to 1 so that reset release never looks like a start bit.
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops to let metastability settle before the line is used.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: start / DATA_BITS payload (LSB first) / optional parity / stop.
// Optional feature macro: RX_MAJORITY_VOTE_EN replaces each single-point
// sample with a 2-of-3 vote over neighbouring synchronized samples.
// DATA_BITS is expected to be at least 2.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int COUNTS_PER_BIT  = 434,
  parameter int DATA_BITS       = 8,
  parameter int CLOCK_CTR_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  input  logic [1:0]           parity_type,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_error,
  output logic                 framing_error
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [CLOCK_CTR_WIDTH-1:0] BIT_END = CLOCK_CTR_WIDTH'(COUNTS_PER_BIT - 1);
  localparam logic [CLOCK_CTR_WIDTH-1:0] CTR_ONE = CLOCK_CTR_WIDTH'(1);

`ifdef RX_MAJORITY_VOTE_EN
  // The start-bit vote is centred on the mid point, so it can only be
  // resolved one cycle after the nominal mid-bit count.
  localparam logic [CLOCK_CTR_WIDTH-1:0] START_POINT = CLOCK_CTR_WIDTH'(COUNTS_PER_BIT / 2);
`else
  localparam logic [CLOCK_CTR_WIDTH-1:0] START_POINT = CLOCK_CTR_WIDTH'(COUNTS_PER_BIT / 2 - 1);
`endif

  logic                       rx_s;
  logic                       rx_prev;
  logic                       sample;

  rx_state_t                  state, state_next;
  logic [CLOCK_CTR_WIDTH-1:0] counter, counter_next;
  logic [IDX_W-1:0]           bit_idx, bit_idx_next;
  logic [DATA_BITS-1:0]       shift_reg, shift_reg_next;
  logic [1:0]                 parity_mode, parity_mode_next;
  logic                       parity_bad, parity_bad_next;
  logic                       expected_parity;
  logic [DATA_BITS-1:0]       data_out_next;
  logic                       data_valid_next;
  logic                       parity_error_next;
  logic                       framing_error_next;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (serial_in),
    .q   (rx_s)
  );

  // Remember the previous synchronized level so only a genuine 1->0 edge starts a frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_prev <= 1'b1;
    end else begin
      rx_prev <= rx_s;
    end
  end

`ifdef RX_MAJORITY_VOTE_EN
  logic [1:0] vote_hist;

  // Keep the two most recent synchronized samples for the 2-of-3 vote.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vote_hist <= 2'b11;
    end else begin
      vote_hist <= {vote_hist[0], rx_s};
    end
  end

  // Majority of the line at the current count and the two counts before it.
  always_comb begin
    sample = (vote_hist[1] & vote_hist[0]) |
             (vote_hist[1] & rx_s) |
             (vote_hist[0] & rx_s);
  end
`else
  // Single sample of the synchronized line at the decision point.
  always_comb begin
    sample = rx_s;
  end
`endif

  // Parity the received payload should carry for the mode latched at frame start.
  always_comb begin
    expected_parity = (parity_mode == PARITY_ODD) ? ~^shift_reg : ^shift_reg;
  end

  // State register plus all datapath and output registers of the receiver.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= RX_IDLE;
      counter       <= '0;
      bit_idx       <= '0;
      shift_reg     <= '0;
      parity_mode   <= PARITY_NONE;
      parity_bad    <= 1'b0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      state         <= state_next;
      counter       <= counter_next;
      bit_idx       <= bit_idx_next;
      shift_reg     <= shift_reg_next;
      parity_mode   <= parity_mode_next;
      parity_bad    <= parity_bad_next;
      data_out      <= data_out_next;
      data_valid    <= data_valid_next;
      parity_error  <= parity_error_next;
      framing_error <= framing_error_next;
    end
  end

  // Frame sequencing: bit timing, sampling, parity check and result publication.
  always_comb begin
    state_next         = state;
    counter_next       = counter;
    bit_idx_next       = bit_idx;
    shift_reg_next     = shift_reg;
    parity_mode_next   = parity_mode;
    parity_bad_next    = parity_bad;
    data_out_next      = data_out;
    data_valid_next    = 1'b0;
    parity_error_next  = parity_error;
    framing_error_next = framing_error;

    case (state)
      RX_IDLE: begin
        counter_next = '0;
        if (rx_prev && !rx_s) begin
          state_next       = RX_START;
          bit_idx_next     = '0;
          parity_bad_next  = 1'b0;
          parity_mode_next = normalize_parity(parity_type);
        end
      end

      RX_START: begin
        if (counter == START_POINT) begin
          counter_next = '0;
          state_next   = sample ? RX_IDLE : RX_DATA;
        end else begin
          counter_next = counter + CTR_ONE;
        end
      end

      RX_DATA: begin
        if (counter == BIT_END) begin
          counter_next   = '0;
          shift_reg_next = {sample, shift_reg[DATA_BITS-1:1]};
          if (bit_idx == LAST_IDX) begin
            bit_idx_next = '0;
            state_next   = (parity_mode != PARITY_NONE) ? RX_PARITY : RX_STOP;
          end else begin
            bit_idx_next = bit_idx + IDX_W'(1);
          end
        end else begin
          counter_next = counter + CTR_ONE;
        end
      end

      RX_PARITY: begin
        if (counter == BIT_END) begin
          counter_next    = '0;
          parity_bad_next = (sample != expected_parity);
          state_next      = RX_STOP;
        end else begin
          counter_next = counter + CTR_ONE;
        end
      end

      RX_STOP: begin
        if (counter == BIT_END) begin
          counter_next       = '0;
          data_out_next      = shift_reg;
          parity_error_next  = (parity_mode != PARITY_NONE) && parity_bad;
          framing_error_next = !sample;
          data_valid_next    = 1'b1;
          state_next         = RX_IDLE;
        end else begin
          counter_next = counter + CTR_ONE;
        end
      end

      default: begin
        state_next   = RX_IDLE;
        counter_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit; the bench plays the
// transmitter. Optional feature macro: RX_MAJORITY_VOTE_EN adds a
// single-cycle-inversion frame and accounts for the extra cycle of latency.
module tb_uart_receiver;

  localparam int CPB  = 16;
  localparam int DB   = 8;
  localparam int HALF = CPB / 2;
`ifdef RX_MAJORITY_VOTE_EN
  localparam int VOTE_SHIFT = 1;
`else
  localparam int VOTE_SHIFT = 0;
`endif
  localparam int LAT_NOPAR = HALF + (DB + 1) * CPB + 3 + VOTE_SHIFT;
  localparam int LAT_PAR   = HALF + (DB + 2) * CPB + 3 + VOTE_SHIFT;

  logic          clk;
  logic          rst;
  logic          serial_in;
  logic [1:0]    parity_type;
  logic [DB-1:0] data_out;
  logic          data_valid;
  logic          parity_error;
  logic          framing_error;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int start_cyc    = 0;
  int dv_cyc       = 0;
  int pulse_count  = 0;
  bit long_pulse   = 1'b0;
  bit dv_prev      = 1'b0;
  logic [DB-1:0] data_q[$];
  logic          perr_q[$];
  logic          ferr_q[$];

  uart_receiver #(
    .COUNTS_PER_BIT  (CPB),
    .DATA_BITS       (DB),
    .CLOCK_CTR_WIDTH (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .serial_in     (serial_in),
    .parity_type   (parity_type),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .parity_error  (parity_error),
    .framing_error (framing_error)
  );

  // 10 time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle count used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every data_valid pulse together with the outputs published with it.
  always @(posedge clk) begin
    #1;
    if (data_valid === 1'b1) begin
      if (dv_prev) long_pulse = 1'b1;
      pulse_count++;
      dv_cyc = cyc;
      data_q.push_back(data_out);
      perr_q.push_back(parity_error);
      ferr_q.push_back(framing_error);
    end
    dv_prev = (data_valid === 1'b1);
  end

  // Hard stop in case something never returns.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic drive_bit(input logic b);
    serial_in = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input bit par_en,
                            input logic par_bit, input logic stop_bit);
    @(posedge clk);
    #1;
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    if (par_en) drive_bit(par_bit);
    drive_bit(stop_bit);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    serial_in = 1'b1;
    parity_type = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (data_out !== 8'h00) begin
      tests_failed++; $display("[TB] FAIL reset_data: got %h, expected %h", data_out, 8'h00);
    end
    tests_run++;
    if (data_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_valid: got %b, expected 0", data_valid);
    end
    tests_run++;
    if (parity_error !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_perr: got %b, expected 0", parity_error);
    end
    tests_run++;
    if (framing_error !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_ferr: got %b, expected 0", framing_error);
    end
    rst = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_no_parity();
    int base;
    base = pulse_count;
    parity_type = 2'd0;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if (pulse_count !== base + 1) begin
      tests_failed++; $display("[TB] FAIL nopar_pulses: got %0d, expected %0d", pulse_count - base, 1);
    end
    tests_run++;
    if (data_out !== 8'hA5) begin
      tests_failed++; $display("[TB] FAIL nopar_data: got %h, expected %h", data_out, 8'hA5);
    end
    tests_run++;
    if (parity_error !== 1'b0 || framing_error !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL nopar_errors: got perr=%b ferr=%b, expected 0 0", parity_error, framing_error);
    end
    tests_run++;
    if (dv_cyc - start_cyc !== LAT_NOPAR) begin
      tests_failed++; $display("[TB] FAIL nopar_latency: got %0d, expected %0d", dv_cyc - start_cyc, LAT_NOPAR);
    end
    tests_run++;
    if (long_pulse !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL nopar_pulse_width: got multi-cycle pulse, expected single cycle");
    end
  endtask

  task automatic test_parity_map();
    parity_type = 2'd3;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if (data_out !== 8'h3C || framing_error !== 1'b0 || parity_error !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL map3_result: got data=%h perr=%b ferr=%b, expected 3c 0 0", data_out, parity_error, framing_error);
    end
    tests_run++;
    if (dv_cyc - start_cyc !== LAT_NOPAR) begin
      tests_failed++; $display("[TB] FAIL map3_latency: got %0d, expected %0d", dv_cyc - start_cyc, LAT_NOPAR);
    end
  endtask

  task automatic test_odd_parity();
    parity_type = 2'd1;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if (parity_error !== 1'b0 || data_out !== 8'h3C) begin
      tests_failed++; $display("[TB] FAIL odd_good: got perr=%b data=%h, expected 0 3c", parity_error, data_out);
    end
    tests_run++;
    if (dv_cyc - start_cyc !== LAT_PAR) begin
      tests_failed++; $display("[TB] FAIL odd_latency: got %0d, expected %0d", dv_cyc - start_cyc, LAT_PAR);
    end
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if (parity_error !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL odd_bad_perr: got %b, expected 1", parity_error);
    end
    tests_run++;
    if (data_out !== 8'h3C || framing_error !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL odd_bad_data: got data=%h ferr=%b, expected 3c 0", data_out, framing_error);
    end
  endtask

  task automatic test_parity_latch();
    parity_type = 2'd2;
    fork
      send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
      begin
        repeat (40) @(posedge clk);
        parity_type = 2'd0;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if (framing_error !== 1'b0 || parity_error !== 1'b0 || data_out !== 8'h3C) begin
      tests_failed++; $display("[TB] FAIL latch_result: got data=%h perr=%b ferr=%b, expected 3c 0 0", data_out, parity_error, framing_error);
    end
    tests_run++;
    if (dv_cyc - start_cyc !== LAT_PAR) begin
      tests_failed++; $display("[TB] FAIL latch_latency: got %0d, expected %0d", dv_cyc - start_cyc, LAT_PAR);
    end
  endtask

  task automatic test_framing();
    int base;
    base = pulse_count;
    parity_type = 2'd0;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if (pulse_count !== base + 1) begin
      tests_failed++; $display("[TB] FAIL frame_pulses: got %0d, expected %0d", pulse_count - base, 1);
    end
    tests_run++;
    if (framing_error !== 1'b1 || data_out !== 8'h55) begin
      tests_failed++; $display("[TB] FAIL frame_err: got ferr=%b data=%h, expected 1 55", framing_error, data_out);
    end
    repeat (5 * CPB) @(posedge clk);
    #1;
    tests_run++;
    if (pulse_count !== base + 1) begin
      tests_failed++; $display("[TB] FAIL frame_held_low: got %0d pulses, expected %0d", pulse_count - base, 1);
    end
    serial_in = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    #1;
  endtask

  task automatic test_glitch();
    int base;
    base = pulse_count;
    @(posedge clk);
    #1;
    serial_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    serial_in = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
    tests_run++;
    if (pulse_count !== base) begin
      tests_failed++; $display("[TB] FAIL glitch_pulses: got %0d, expected 0", pulse_count - base);
    end
    tests_run++;
    if (data_out !== 8'h55 || framing_error !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL glitch_hold: got data=%h ferr=%b, expected 55 1", data_out, framing_error);
    end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    base = pulse_count;
    @(posedge clk);
    #1;
    serial_in = 1'b0;
    repeat (3 * CPB + HALF) @(posedge clk);
    #1;
    rst = 1'b0;
    serial_in = 1'b1;
    #2;
    tests_run++;
    if (data_out !== 8'h00 || data_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL midrst_outputs: got data=%h valid=%b, expected 00 0", data_out, data_valid);
    end
    tests_run++;
    if (parity_error !== 1'b0 || framing_error !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL midrst_flags: got perr=%b ferr=%b, expected 0 0", parity_error, framing_error);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (12 * CPB) @(posedge clk);
    #1;
    tests_run++;
    if (pulse_count !== base) begin
      tests_failed++; $display("[TB] FAIL midrst_pulses: got %0d, expected 0", pulse_count - base);
    end
    parity_type = 2'd0;
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if (pulse_count !== base + 1 || data_out !== 8'h81) begin
      tests_failed++; $display("[TB] FAIL midrst_resume: got pulses=%0d data=%h, expected 1 81", pulse_count - base, data_out);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    int n;
    base = pulse_count;
    parity_type = 2'd2;
    send_frame(8'h00, 1'b1, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    n = data_q.size();
    tests_run++;
    if (pulse_count !== base + 2) begin
      tests_failed++; $display("[TB] FAIL b2b_pulses: got %0d, expected %0d", pulse_count - base, 2);
    end
    if (n >= 2) begin
      tests_run++;
      if (data_q[n-2] !== 8'h00 || data_q[n-1] !== 8'hFF) begin
        tests_failed++; $display("[TB] FAIL b2b_data: got %h %h, expected 00 ff", data_q[n-2], data_q[n-1]);
      end
      tests_run++;
      if (perr_q[n-2] !== 1'b0 || perr_q[n-1] !== 1'b0 || ferr_q[n-2] !== 1'b0 || ferr_q[n-1] !== 1'b0) begin
        tests_failed++; $display("[TB] FAIL b2b_errors: got perr=%b%b ferr=%b%b, expected 00 00", perr_q[n-2], perr_q[n-1], ferr_q[n-2], ferr_q[n-1]);
      end
    end else begin
      tests_run++;
      tests_failed++; $display("[TB] FAIL b2b_log: got %0d logged frames, expected at least 2", n);
    end
    tests_run++;
    if (dv_cyc - start_cyc !== LAT_PAR) begin
      tests_failed++; $display("[TB] FAIL b2b_latency: got %0d, expected %0d", dv_cyc - start_cyc, LAT_PAR);
    end
  endtask

`ifdef RX_MAJORITY_VOTE_EN
  task automatic test_vote_flicker();
    logic [DB-1:0] d;
    d = 8'hA5;
    parity_type = 2'd0;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) begin
      serial_in = d[i];
      repeat (9) @(posedge clk);
      #1;
      serial_in = ~d[i];
      @(posedge clk);
      #1;
      serial_in = d[i];
      repeat (CPB - 10) @(posedge clk);
      #1;
    end
    drive_bit(1'b1);
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if (data_out !== 8'hA5 || framing_error !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL vote_flicker: got data=%h ferr=%b, expected a5 0", data_out, framing_error);
    end
  endtask
`endif

  // Run the scenarios in order and print the summary.
  initial begin
    test_reset();
    test_no_parity();
    test_parity_map();
    test_odd_parity();
    test_parity_latch();
    test_framing();
    test_glitch();
    test_reset_mid_frame();
    test_back_to_back();
`ifdef RX_MAJORITY_VOTE_EN
    test_vote_flicker();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
